result_tx_framer: RTL

//  Transmit-side companion to the serial work receiver. Captures result events from

---
 rtl/miner_defs.sv | 34 +++
 rtl/result_fifo.sv | 50 +++++
 rtl/result_tx_framer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/miner_defs.sv
// Shared constants, FSM encoding and checksum helpers for the miner result path.
package miner_defs;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0]  RES_TYPE_NONCE    = 8'h01;
    localparam logic [7:0]  RES_TYPE_DONE     = 8'h02;
    localparam int unsigned FRAME_LEN         = 7;
    localparam int unsigned FRAME_W           = FRAME_LEN * 8;
    localparam logic [7:0]  CRC8_POLY         = 8'h07;
    localparam int unsigned RESULT_W          = 33;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSend = 2'd2,
        StWait = 2'd3
    } tx_state_e;

    // XOR checksum over TYPE and the four nonce bytes.
    function automatic logic [7:0] xor_chk(input logic [7:0] res_type, input logic [31:0] data);
        return res_type ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

    // One byte step of CRC-8, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO for captured result events; a push while full is accepted only
// when a pop happens in the same cycle.
module result_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             accept_o,
    output logic             drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign empty_o  = (wptr_q == rptr_q);
    assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop   = pop_i && !empty_o;
    assign accept_o = push_i && (!full_o || do_pop);
    assign drop_o   = push_i && full_o && !do_pop;
    assign rdata_o  = mem_q[rptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (accept_o) wptr_q <= wptr_q + 1'b1;
            if (do_pop)   rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (accept_o) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/result_tx_framer.sv
// Queues result events and emits each as a 7-byte frame to the serial_tx byte interface.
// Optional feature: define RESULT_CRC8_EN to replace the XOR check byte with CRC-8 (0x07).
module result_tx_framer
    import miner_defs::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_result_i,
    input  logic        result_done_i,
    input  logic [31:0] result_data_i,
    output logic [7:0]  tx_data_o,
    output logic        new_tx_data_o,
    input  logic        tx_busy_i,
    output logic        busy_o,
    output logic        overflow_o
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    tx_state_e            state_q;
    logic [2:0]           byte_idx_q;
    logic [FRAME_W-1:0]   frame_q;
    logic [7:0]           tx_data_q;
    logic                 new_tx_data_q;
    logic                 busy_q;
    logic                 overflow_q;

    logic [RESULT_W-1:0]  fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 fifo_accept;
    logic                 fifo_drop;
    logic [7:0]           head_type;
    logic [7:0]           head_chk;
    logic [7:0]           head_byte;

`ifdef RESULT_CRC8_EN
    logic [7:0]           crc_q;
`endif

    result_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (new_result_i),
        .wdata_i  ({result_done_i, result_data_i}),
        .pop_i    (fifo_pop),
        .rdata_o  (fifo_rdata),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .accept_o (fifo_accept),
        .drop_o   (fifo_drop)
    );

    assign fifo_pop  = (state_q == StLoad);
    assign head_type = fifo_rdata[32] ? RES_TYPE_DONE : RES_TYPE_NONCE;
    assign head_byte = frame_q[FRAME_W-1 -: 8];

`ifdef RESULT_CRC8_EN
    // CRC is accumulated while the frame goes out; the loaded check byte is unused.
    assign head_chk = 8'h00;
`else
    assign head_chk = xor_chk(head_type, fifo_rdata[31:0]);
`endif

    // Framer FSM with registered outputs; busy tracks next-cycle state and FIFO occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            byte_idx_q    <= '0;
            frame_q       <= '0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
`ifdef RESULT_CRC8_EN
            crc_q         <= 8'h00;
`endif
        end else begin
            new_tx_data_q <= 1'b0;
            if (fifo_drop) overflow_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q <= StLoad;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= fifo_accept;
                    end
                end
                StLoad: begin
                    frame_q    <= {SYNC_BYTE, head_type, fifo_rdata[31:0], head_chk};
                    byte_idx_q <= '0;
                    busy_q     <= 1'b1;
                    state_q    <= StSend;
`ifdef RESULT_CRC8_EN
                    crc_q      <= 8'h00;
`endif
                end
                StSend: begin
                    if (!tx_busy_i) begin
`ifdef RESULT_CRC8_EN
                        tx_data_q <= (byte_idx_q == LAST_IDX) ? crc_q : head_byte;
                        // SYNC and the check byte itself are outside the CRC.
                        if (byte_idx_q != 3'd0 && byte_idx_q != LAST_IDX) begin
                            crc_q <= crc8_byte(crc_q, head_byte);
                        end
`else
                        tx_data_q <= head_byte;
`endif
                        frame_q       <= {frame_q[FRAME_W-9:0], 8'h00};
                        new_tx_data_q <= 1'b1;
                        state_q       <= StWait;
                    end
                end
                StWait: begin
                    // Guard cycle: serial_tx raises tx_busy only now.
                    if (byte_idx_q == LAST_IDX) begin
                        if (!fifo_empty) begin
                            state_q <= StLoad;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= fifo_accept;
                        end
                    end else begin
                        byte_idx_q <= byte_idx_q + 3'd1;
                        state_q    <= StSend;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_data_o     = tx_data_q;
    assign new_tx_data_o = new_tx_data_q;
    assign busy_o        = busy_q;
    assign overflow_o    = overflow_q;

endmodule
